// File: rtl/uart_rx_if.sv
// ============================================================================
// Module   : uart_rx_if
// Brief    : Receive-side bundle: serial line in, done strobe and word out.
//            Optional o_frame_err signal when UART_RX_FRAME_ERR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_if #(
   parameter int PAYLOAD_BITS = 8
);
   logic                    i_serial_data;
   logic                    o_rx_done;
   logic [PAYLOAD_BITS-1:0] o_data;
`ifdef UART_RX_FRAME_ERR_EN
   logic                    o_frame_err;

   modport master (
      input  i_serial_data,
      output o_rx_done,
      output o_data,
      output o_frame_err
   );

   modport slave (
      input  i_serial_data,
      input  o_rx_done,
      input  o_data,
      input  o_frame_err
   );
`else
   modport master (
      input  i_serial_data,
      output o_rx_done,
      output o_data
   );

   modport slave (
      input  i_serial_data,
      input  o_rx_done,
      input  o_data
   );
`endif
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : Mid-bit sampling serial receiver (start, PAYLOAD_BITS LSB first,
//            stop). Define UART_RX_FRAME_ERR_EN to add the o_frame_err strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
   parameter int BIT_RATE     = 115200,
   parameter int CLK_FREQ     = 10_000_000,
   parameter int PAYLOAD_BITS = 8
) (
   input  wire logic clk,
   input  wire logic reset_n,
   uart_rx_if.master bus
);

   localparam int c_cycles_per_bit = CLK_FREQ / BIT_RATE;
   localparam int c_half_bit       = c_cycles_per_bit / 2;
   localparam int c_cnt_w          = (c_cycles_per_bit > 1) ? $clog2(c_cycles_per_bit) : 1;
   localparam int c_bit_w          = $clog2(PAYLOAD_BITS + 1);

   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_cycles_per_bit - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(c_half_bit - 1);
   localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(PAYLOAD_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t                  r_state;
   logic                    r_sync1;
   logic                    r_sync2;
   logic [c_cnt_w-1:0]      r_cnt;
   logic [c_bit_w-1:0]      r_bit_cnt;
   logic [PAYLOAD_BITS-1:0] r_shift;
   logic [PAYLOAD_BITS-1:0] r_data;
   logic                    r_rx_done;
   logic                    r_frame_err;
   logic                    w_rx_s;

   // Resetting to 1 keeps the release of reset from looking like a start edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= bus.i_serial_data;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rx_s = r_sync2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_rx_done   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_done   <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt     <= '0;
               r_bit_cnt <= '0;
               if (!w_rx_s) begin
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (r_cnt == c_cnt_half) begin
                  r_cnt   <= '0;
                  r_state <= w_rx_s ? S_IDLE : S_DATA;
               end else begin
                  r_cnt <= r_cnt + c_cnt_w'(1);
               end
            end
            S_DATA: begin
               if (r_cnt == c_cnt_last) begin
                  r_cnt   <= '0;
                  r_shift <= {w_rx_s, r_shift[PAYLOAD_BITS-1:1]};
                  if (r_bit_cnt == c_bit_last) begin
                     r_bit_cnt <= '0;
                     r_state   <= S_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
                  end
               end else begin
                  r_cnt <= r_cnt + c_cnt_w'(1);
               end
            end
            S_STOP: begin
               // Leaving at mid-stop lets a start bit right after one stop bit be caught.
               if (r_cnt == c_cnt_last) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
                  if (w_rx_s) begin
                     r_data    <= r_shift;
                     r_rx_done <= 1'b1;
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + c_cnt_w'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_rx_done = r_rx_done;
   assign bus.o_data    = r_data;
`ifdef UART_RX_FRAME_ERR_EN
   assign bus.o_frame_err = r_frame_err;
`else
   logic w_unused_frame_err;
   assign w_unused_frame_err = r_frame_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed bench for uart_rx with a byte/timestamp scoreboard.
//            Honours UART_RX_FRAME_ERR_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

   localparam int  c_clk_ns  = 100;
   localparam int  c_cpb     = 10_000_000 / 115200;
   localparam int  c_half    = c_cpb / 2;
   localparam real c_bit_ns  = 1.0e9 / 115200.0;
   // Line fall to done seen on the following negedge: 2-3 sync cycles plus the stop offset.
   localparam real c_lat_nom = real'((c_half + 9 * c_cpb) * c_clk_ns);
   localparam real c_lat_lo  = c_lat_nom + 100.0;
   localparam real c_lat_hi  = c_lat_nom + 500.0;

   typedef struct {
      logic [7:0] data;
      realtime    t_start;
   } exp_t;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;
   int   done_cnt;
   int   ferr_cnt;
   exp_t sb[$];

   uart_rx_if #(.PAYLOAD_BITS(8)) bus ();

   uart_rx #(
      .BIT_RATE    (115200),
      .CLK_FREQ    (10_000_000),
      .PAYLOAD_BITS(8)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #(c_clk_ns / 2) clk = ~clk;

   always @(negedge clk) begin
      if (bus.o_rx_done === 1'b1) begin
         exp_t    e;
         realtime lat;
         done_cnt++;
         checks++;
         assert (sb.size() != 0)
         else begin
            errors++;
            $error("FAIL unexpected_done observed data=%h with empty scoreboard", bus.o_data);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (bus.o_data === e.data)
            else begin
               errors++;
               $error("FAIL frame_data observed=%h expected=%h", bus.o_data, e.data);
            end
            lat = $realtime - e.t_start;
            checks++;
            assert (lat >= c_lat_lo && lat <= c_lat_hi)
            else begin
               errors++;
               $error("FAIL done_latency observed=%0t ns expected %0t..%0t ns", lat, c_lat_lo, c_lat_hi);
            end
         end
      end
`ifdef UART_RX_FRAME_ERR_EN
      if (bus.o_frame_err === 1'b1) ferr_cnt++;
`endif
   end

   // stop_ns lets a bench step shorten the stop bit (used for the low-stop case).
   task automatic send_frame(input logic [7:0] d, input logic stop_val,
                             input realtime stop_ns, input bit expect_ok);
      if (expect_ok) sb.push_back('{data: d, t_start: $realtime});
      bus.i_serial_data = 1'b0;
      #(c_bit_ns);
      for (int i = 0; i < 8; i++) begin
         bus.i_serial_data = d[i];
         #(c_bit_ns);
      end
      bus.i_serial_data = stop_val;
      #(stop_ns);
      bus.i_serial_data = 1'b1;
   endtask

   task automatic check_int(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic check_data(input string tag, input logic [7:0] expected);
      checks++;
      assert (bus.o_data === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, bus.o_data, expected);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      done_cnt = 0;
      ferr_cnt = 0;
      reset_n  = 1'b0;
      bus.i_serial_data = 1'b1;

      // Reset and idle line
      #50;
      checks++;
      assert (bus.o_rx_done === 1'b0)
      else begin
         errors++;
         $error("FAIL reset_done observed=%b expected=0", bus.o_rx_done);
      end
      check_data("reset_data", 8'h00);
      #50;
      @(negedge clk);
      reset_n = 1'b1;
      #203;
      check_int("idle_no_done", done_cnt, 0);
      check_data("idle_data", 8'h00);

      // Single frame
      send_frame(8'h16, 1'b1, c_bit_ns, 1'b1);
      #(2.0 * c_bit_ns);
      check_int("frame16_done_count", done_cnt, 1);
      check_data("frame16_data", 8'h16);

      // Back-to-back frames, single stop bit
      send_frame(8'h32, 1'b1, c_bit_ns, 1'b1);
      send_frame(8'hAF, 1'b1, c_bit_ns, 1'b1);
      #(2.0 * c_bit_ns);
      check_int("b2b_done_count", done_cnt, 3);
      check_data("b2b_data", 8'hAF);

      // Short low glitch on an idle line
      bus.i_serial_data = 1'b0;
      #1000;
      bus.i_serial_data = 1'b1;
      #(2.0 * c_bit_ns);
      check_int("glitch_done_count", done_cnt, 3);
      check_data("glitch_data", 8'hAF);

      // Low stop bit, released soon after mid-stop so the restart is a glitch
      send_frame(8'h55, 1'b0, 0.55 * c_bit_ns, 1'b0);
      #(3.0 * c_bit_ns);
      check_int("ferr_done_count", done_cnt, 3);
      check_data("ferr_data", 8'hAF);
`ifdef UART_RX_FRAME_ERR_EN
      check_int("ferr_pulse_count", ferr_cnt, 1);
`endif

      // Reset during data bit 4 of 0xA5
      bus.i_serial_data = 1'b0;
      #(c_bit_ns);
      for (int i = 0; i < 3; i++) begin
         bus.i_serial_data = (8'hA5 >> i) & 8'h01;
         #(c_bit_ns);
      end
      bus.i_serial_data = 1'b0;
      #(0.5 * c_bit_ns);
      reset_n = 1'b0;
      bus.i_serial_data = 1'b1;
      #250;
      check_data("abort_reset_data", 8'h00);
      #250;
      @(negedge clk);
      reset_n = 1'b1;
      #(2.0 * c_bit_ns);
      check_int("abort_done_count", done_cnt, 3);
      check_data("abort_data", 8'h00);

      // Clean frame after the abort
      send_frame(8'h3C, 1'b1, c_bit_ns, 1'b1);
      #(2.0 * c_bit_ns);
      check_int("frame3c_done_count", done_cnt, 4);
      check_data("frame3c_data", 8'h3C);
      check_int("scoreboard_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
